instruction_fetch_ctrl: RTL

- Fetch-stage sequencer for the pipelined core.
- Owns the program counter and drives the address of the asynchronous-read program memory ROM.
- Captures the returned instruction into the IF/ID pipeline register.
- Arbitrates three sources of next-PC: sequential, stall-hold and branch/jump redirect. Detects illegal fetches: out-of-window or misaligned.

---
 rtl/fetch_pkg.sv | 37 +++
 rtl/fetch_window_check.sv | 35 +++
 rtl/instruction_fetch_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch controller:
//   - fetch_state_e   : fetch sequencer states (BOOT / RUN / FAULT)
//   - FETCH_NOP_INSTR : bubble instruction (addi x0,x0,0)
//   - FETCH_RESET_PC  : default PC after reset (text segment base)
//   - window_end()    : first byte address past the legal fetch window
//   - sat_inc()       : saturating 32-bit increment for event counters
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FAULT = 2'b10
    } fetch_state_e;

    localparam logic [31:0] FETCH_NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] FETCH_RESET_PC  = 32'h0040_0000;

    // Computed in 64 bits so a window ending exactly at 2^32 does not wrap.
    function automatic logic [63:0] window_end(input logic [63:0] base,
                                               input logic [63:0] depth_words);
        return base + (depth_words << 2);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        logic [31:0] result;
        if (value == 32'hFFFF_FFFF) begin
            result = value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fetch_window_check.sv
// -----------------------------------------------------------------------------
// fetch_window_check
// Combinational legality check of a fetch address against the ROM window
// [RESET_PC, RESET_PC + 4*MEMORY_DEPTH). The comparison uses the full address
// width (no truncation to ROM index bits).
// Ports:
//   addr      in  DATA_WIDTH  byte address to check
//   in_window out 1           address lies inside the ROM window
//   aligned   out 1           address is word aligned
// -----------------------------------------------------------------------------
module fetch_window_check
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEMORY_DEPTH = 256,
    parameter logic [DATA_WIDTH-1:0] RESET_PC     = DATA_WIDTH'(FETCH_RESET_PC)
) (
    input  logic [DATA_WIDTH-1:0] addr,
    output logic                  in_window,
    output logic                  aligned
);

    localparam logic [63:0] WIN_BASE = 64'(RESET_PC);
    localparam logic [63:0] WIN_END  = window_end(WIN_BASE, 64'(MEMORY_DEPTH));

    logic [63:0] addr_wide_s;

    // Widen the address and compare against both window bounds.
    always_comb begin
        addr_wide_s = 64'(addr);
        in_window   = (addr_wide_s >= WIN_BASE) && (addr_wide_s < WIN_END);
        aligned     = (addr[1:0] == 2'b00);
    end

endmodule

// File: rtl/instruction_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// instruction_fetch_ctrl
// Fetch-stage sequencer: owns the PC, addresses the asynchronous ROM and
// captures the returned word into the IF/ID register. Next-PC sources are
// sequential (+4), stall-hold and branch/jump redirect. Out-of-window or
// misaligned fetches latch a sticky fault that only reset clears.
// Optional build macro FETCH_PERF_COUNTERS_EN adds saturating fetch, stall
// and flush counters (Fetch_Count_o, Stall_Count_o, Flush_Count_o).
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   Stall_i               hold PC and IF/ID
//   Redirect_i/_PC_i      taken branch/jump and its target
//   Mem_Address_o         ROM byte address (the PC register)
//   Mem_Instruction_i     ROM read data, same cycle
//   IF_ID_PC_o/_Instruction_o/_Valid_o  IF/ID pipeline register
//   Fault_o, Fault_PC_o   sticky illegal-fetch flag and offending address
// -----------------------------------------------------------------------------
module instruction_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEMORY_DEPTH = 256,
    parameter logic [DATA_WIDTH-1:0] RESET_PC     = DATA_WIDTH'(FETCH_RESET_PC),
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR    = DATA_WIDTH'(FETCH_NOP_INSTR)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall_i,
    input  logic                  Redirect_i,
    input  logic [DATA_WIDTH-1:0] Redirect_PC_i,
    output logic [DATA_WIDTH-1:0] Mem_Address_o,
    input  logic [DATA_WIDTH-1:0] Mem_Instruction_i,
    output logic [DATA_WIDTH-1:0] IF_ID_PC_o,
    output logic [DATA_WIDTH-1:0] IF_ID_Instruction_o,
    output logic                  IF_ID_Valid_o,
`ifdef FETCH_PERF_COUNTERS_EN
    output logic [31:0]           Fetch_Count_o,
    output logic [31:0]           Stall_Count_o,
    output logic [31:0]           Flush_Count_o,
`endif
    output logic                  Fault_o,
    output logic [DATA_WIDTH-1:0] Fault_PC_o
);

    localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

    fetch_state_e          state_r, state_nxt_s;
    logic [DATA_WIDTH-1:0] pc_r, pc_nxt_s;
    logic [DATA_WIDTH-1:0] ifid_pc_r, ifid_pc_nxt_s;
    logic [DATA_WIDTH-1:0] ifid_instr_r, ifid_instr_nxt_s;
    logic                  ifid_valid_r, ifid_valid_nxt_s;
    logic                  fault_r, fault_nxt_s;
    logic [DATA_WIDTH-1:0] fault_pc_r, fault_pc_nxt_s;

    logic [DATA_WIDTH-1:0] check_addr_s;
    logic                  check_in_window_s;
    logic                  check_aligned_s;

    // One checker serves both paths: in RUN a redirect takes priority, so the
    // target is checked then; otherwise the current PC is checked.
    always_comb begin
        if (Redirect_i) begin
            check_addr_s = Redirect_PC_i;
        end else begin
            check_addr_s = pc_r;
        end
    end

    fetch_window_check #(
        .DATA_WIDTH   (DATA_WIDTH),
        .MEMORY_DEPTH (MEMORY_DEPTH),
        .RESET_PC     (RESET_PC)
    ) u_window_check (
        .addr      (check_addr_s),
        .in_window (check_in_window_s),
        .aligned   (check_aligned_s)
    );

    // Next-state, next-PC and IF/ID selection.
    always_comb begin
        state_nxt_s      = state_r;
        pc_nxt_s         = pc_r;
        ifid_pc_nxt_s    = ifid_pc_r;
        ifid_instr_nxt_s = ifid_instr_r;
        ifid_valid_nxt_s = ifid_valid_r;
        fault_nxt_s      = fault_r;
        fault_pc_nxt_s   = fault_pc_r;
        case (state_r)
            ST_BOOT: begin
                // PC and the reset bubble are held while the ROM settles.
                state_nxt_s = ST_RUN;
            end
            ST_RUN: begin
                if (Redirect_i) begin
                    ifid_instr_nxt_s = NOP_INSTR;
                    ifid_valid_nxt_s = 1'b0;
                    if (!check_aligned_s) begin
                        state_nxt_s    = ST_FAULT;
                        fault_nxt_s    = 1'b1;
                        fault_pc_nxt_s = Redirect_PC_i;
                    end else begin
                        pc_nxt_s = Redirect_PC_i;
                    end
                end else if (Stall_i) begin
                    pc_nxt_s = pc_r;
                end else if (!(check_in_window_s && check_aligned_s)) begin
                    state_nxt_s      = ST_FAULT;
                    fault_nxt_s      = 1'b1;
                    fault_pc_nxt_s   = pc_r;
                    ifid_instr_nxt_s = NOP_INSTR;
                    ifid_valid_nxt_s = 1'b0;
                end else begin
                    ifid_pc_nxt_s    = pc_r;
                    ifid_instr_nxt_s = Mem_Instruction_i;
                    ifid_valid_nxt_s = 1'b1;
                    pc_nxt_s         = pc_r + PC_STEP;
                end
            end
            ST_FAULT: begin
                fault_nxt_s      = 1'b1;
                ifid_instr_nxt_s = NOP_INSTR;
                ifid_valid_nxt_s = 1'b0;
            end
            default: begin
                // An illegal state encoding is treated as a fault at the PC.
                state_nxt_s      = ST_FAULT;
                fault_nxt_s      = 1'b1;
                fault_pc_nxt_s   = pc_r;
                ifid_instr_nxt_s = NOP_INSTR;
                ifid_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State, PC, IF/ID and fault registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_BOOT;
            pc_r         <= RESET_PC;
            ifid_pc_r    <= {DATA_WIDTH{1'b0}};
            ifid_instr_r <= NOP_INSTR;
            ifid_valid_r <= 1'b0;
            fault_r      <= 1'b0;
            fault_pc_r   <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            pc_r         <= pc_nxt_s;
            ifid_pc_r    <= ifid_pc_nxt_s;
            ifid_instr_r <= ifid_instr_nxt_s;
            ifid_valid_r <= ifid_valid_nxt_s;
            fault_r      <= fault_nxt_s;
            fault_pc_r   <= fault_pc_nxt_s;
        end
    end

    assign Mem_Address_o       = pc_r;
    assign IF_ID_PC_o          = ifid_pc_r;
    assign IF_ID_Instruction_o = ifid_instr_r;
    assign IF_ID_Valid_o       = ifid_valid_r;
    assign Fault_o             = fault_r;
    assign Fault_PC_o          = fault_pc_r;

`ifdef FETCH_PERF_COUNTERS_EN
    logic        run_s, issue_s, stall_s, flush_s;
    logic [31:0] fetch_cnt_r, stall_cnt_r, flush_cnt_r;

    // Event qualifiers mirror the RUN priority order above.
    always_comb begin
        run_s   = (state_r == ST_RUN);
        flush_s = run_s && Redirect_i && check_aligned_s;
        stall_s = run_s && !Redirect_i && Stall_i;
        issue_s = run_s && !Redirect_i && !Stall_i && check_in_window_s && check_aligned_s;
    end

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_r <= 32'd0;
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            if (issue_s) fetch_cnt_r <= sat_inc(fetch_cnt_r);
            if (stall_s) stall_cnt_r <= sat_inc(stall_cnt_r);
            if (flush_s) flush_cnt_r <= sat_inc(flush_cnt_r);
        end
    end

    assign Fetch_Count_o = fetch_cnt_r;
    assign Stall_Count_o = stall_cnt_r;
    assign Flush_Count_o = flush_cnt_r;
`endif

endmodule
